// File: rtl/msg_drop_pkg.sv
// Shared types and decision helpers for the msg_dropper policy controller.
package msg_drop_pkg;

    typedef enum logic [1:0] {
        PASS_ALL = 2'd0,
        DROP_ALL = 2'd1,
        PERIODIC = 2'd2,
        RSVD     = 2'd3
    } drop_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } ctrl_state_e;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } phase_e;

    // Degenerate PERIODIC settings collapse onto the fixed modes; RSVD passes.
    function automatic drop_mode_e resolve_mode(input drop_mode_e mode,
                                                input logic       pass_zero,
                                                input logic       drop_zero);
        drop_mode_e res;
        case (mode)
            DROP_ALL: res = DROP_ALL;
            PERIODIC: begin
                if (drop_zero) begin
                    res = PASS_ALL;
                end else if (pass_zero) begin
                    res = DROP_ALL;
                end else begin
                    res = PERIODIC;
                end
            end
            default:  res = PASS_ALL;
        endcase
        return res;
    endfunction

    function automatic logic drop_for(input drop_mode_e mode, input phase_e ph);
        return (mode == DROP_ALL) || ((mode == PERIODIC) && (ph == DROP));
    endfunction

endpackage

// File: rtl/msg_drop_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/msg_drop_ctrl.sv
// Per-message pass/drop policy for msg_dropper: frozen decision per message,
// boundary-applied configuration, saturating statistics and sticky protocol error.
module msg_drop_ctrl
    import msg_drop_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_pass_cnt,
    input  logic [CNT_W-1:0]  cfg_drop_cnt,
    input  logic              mon_valid,
    input  logic              mon_ready,
    input  logic              mon_sop,
    input  logic              mon_eop,
    input  logic              drop_indication,
    output logic              drop,
    output logic [STAT_W-1:0] msg_cnt,
    output logic [STAT_W-1:0] drop_cnt,
    input  logic              stat_clr,
    output logic              proto_err
);

    ctrl_state_e      state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    drop_mode_e       act_mode_q, act_mode_d;
    logic [CNT_W-1:0] act_pass_q, act_pass_d;
    logic [CNT_W-1:0] act_drop_q, act_drop_d;
    drop_mode_e       sh_mode_q, sh_mode_d;
    logic [CNT_W-1:0] sh_pass_q, sh_pass_d;
    logic [CNT_W-1:0] sh_drop_q, sh_drop_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;
    logic             perr_q, perr_d;

    logic             sop_acc_s, eop_acc_s, in_msg_s;
    logic             complete_s, boundary_s, copy_s, perr_evt_s;
    drop_mode_e       eff_s, sh_eff_s;
    logic [CNT_W-1:0] pcnt_inc_s;

    assign sop_acc_s  = mon_valid & mon_ready & mon_sop;
    assign eop_acc_s  = mon_valid & mon_ready & mon_eop;
    assign in_msg_s   = (state_q == IN_MSG);
    assign complete_s = eop_acc_s & (in_msg_s | sop_acc_s);
    assign boundary_s = eop_acc_s | (~in_msg_s & ~sop_acc_s);
    assign copy_s     = pend_q & boundary_s;
    assign perr_evt_s = (in_msg_s & sop_acc_s) | (~in_msg_s & eop_acc_s & ~sop_acc_s);
    assign eff_s      = resolve_mode(act_mode_q, act_pass_q == '0, act_drop_q == '0);
    assign sh_eff_s   = resolve_mode(sh_mode_q, sh_pass_q == '0, sh_drop_q == '0);
    assign pcnt_inc_s = pcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Message framing state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sop_acc_s && !eop_acc_s) begin
                    state_d = IN_MSG;
                end else begin
                    state_d = IDLE;
                end
            end
            IN_MSG: begin
                if (eop_acc_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = IN_MSG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period advance and decision; a pending config copy restarts the period.
    always_comb begin
        act_mode_d = act_mode_q;
        act_pass_d = act_pass_q;
        act_drop_d = act_drop_q;
        phase_d    = phase_q;
        pcnt_d     = pcnt_q;
        drop_d     = drop_q;
        if (copy_s) begin
            act_mode_d = sh_mode_q;
            act_pass_d = sh_pass_q;
            act_drop_d = sh_drop_q;
            phase_d    = PASS;
            pcnt_d     = '0;
            drop_d     = drop_for(sh_eff_s, PASS);
        end else if (complete_s) begin
            if (eff_s == PERIODIC) begin
                if (phase_q == PASS) begin
                    if (pcnt_inc_s == act_pass_q) begin
                        phase_d = DROP;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d  = pcnt_inc_s;
                    end
                end else begin
                    if (pcnt_inc_s == act_drop_q) begin
                        phase_d = PASS;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d  = pcnt_inc_s;
                    end
                end
            end else begin
                phase_d = PASS;
                pcnt_d  = '0;
            end
            drop_d = drop_for(eff_s, phase_d);
        end else begin
            drop_d = drop_q;
        end
    end

    // Shadow capture (last load wins) and the pending-copy flag.
    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_pass_d = sh_pass_q;
        sh_drop_d = sh_drop_q;
        pend_d    = pend_q;
        if (cfg_load) begin
            sh_mode_d = drop_mode_e'(cfg_mode);
            sh_pass_d = cfg_pass_cnt;
            sh_drop_d = cfg_drop_cnt;
            pend_d    = 1'b1;
        end else if (copy_s) begin
            pend_d    = 1'b0;
        end else begin
            pend_d    = pend_q;
        end
        perr_d = perr_q | perr_evt_s;
    end

    // Control and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PASS;
            pcnt_q     <= '0;
            act_mode_q <= PASS_ALL;
            act_pass_q <= '0;
            act_drop_q <= '0;
            sh_mode_q  <= PASS_ALL;
            sh_pass_q  <= '0;
            sh_drop_q  <= '0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pcnt_q     <= pcnt_d;
            act_mode_q <= act_mode_d;
            act_pass_q <= act_pass_d;
            act_drop_q <= act_drop_d;
            sh_mode_q  <= sh_mode_d;
            sh_pass_q  <= sh_pass_d;
            sh_drop_q  <= sh_drop_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            perr_q     <= perr_d;
        end
    end

    sat_counter #(.WIDTH(STAT_W)) u_msg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (complete_s),
        .clr   (stat_clr),
        .cnt   (msg_cnt)
    );

    sat_counter #(.WIDTH(STAT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_indication),
        .clr   (stat_clr),
        .cnt   (drop_cnt)
    );

    assign drop      = drop_q;
    assign proto_err = perr_q;

endmodule
